// File: rtl/noc_master_arbiter_if.sv
// Request/grant bundle between the processing units and the NoC master arbiter.
// The arbiter side uses modport master and the unit side uses modport slave.
interface noc_master_arbiter_if #(
   parameter int NUM_PROC = 4,
   parameter int DEST_W   = 5
);
   logic [NUM_PROC-1:0]        request_transfer;
   logic [NUM_PROC*DEST_W-1:0] which_processor;
   logic [NUM_PROC-1:0]        tx_last;
   logic [NUM_PROC-1:0]        master_response;
   logic                       grant_valid;
   logic [4:0]                 grant_src;
   logic [DEST_W-1:0]          grant_dest;
   logic                       timeout_err;
   logic                       bad_dest_err;

   modport master (
      input  request_transfer, which_processor, tx_last,
      output master_response, grant_valid, grant_src, grant_dest, timeout_err, bad_dest_err
   );

   modport slave (
      output request_transfer, which_processor, tx_last,
      input  master_response, grant_valid, grant_src, grant_dest, timeout_err, bad_dest_err
   );
endinterface

// File: rtl/noc_master_arbiter.sv
// Round-robin NoC master: grants the network to one processing unit at a time and holds
// the grant until that unit's last flit or a timeout, with a one-cycle release gap.
module noc_master_arbiter #(
   parameter int NUM_PROC = 4,
   parameter int DEST_W   = 5,
   parameter int TIMEOUT  = 256
) (
   input  logic                 clock,
   input  logic                 reset,
   noc_master_arbiter_if.master bus
);
   localparam int PTR_W = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RELEASE = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]    gnt_idx_q, gnt_idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_PROC-1:0] resp_q, resp_d;
   logic [4:0]          src_q, src_d;
   logic [DEST_W-1:0]   dest_q, dest_d;
   logic                tout_err_q, tout_err_d;
   logic                bad_err_q, bad_err_d;

   logic [DEST_W-1:0]   dest_arr [NUM_PROC];
   logic [NUM_PROC-1:0] req_valid;
   logic [NUM_PROC-1:0] req_bad;

   // A request is only eligible when it targets another, existing unit.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PROC; gi++) begin : g_req
         logic [31:0] dest_ext;
         assign dest_arr[gi]  = bus.which_processor[gi*DEST_W +: DEST_W];
         assign dest_ext      = 32'(dest_arr[gi]);
         assign req_valid[gi] = bus.request_transfer[gi]
                                && (dest_ext != 32'(gi))
                                && (dest_ext < 32'(NUM_PROC));
         assign req_bad[gi]   = bus.request_transfer[gi] && !req_valid[gi];
      end
   endgenerate

   logic             pick_found;
   logic [PTR_W-1:0] pick_idx;

   // Scan downward so the candidate closest to the pointer is the last one written.
   always_comb begin
      int               j;
      logic [PTR_W-1:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      j          = 0;
      cand       = '0;
      for (int k = NUM_PROC - 1; k >= 0; k--) begin
         j = int'(rr_ptr_q) + k;
         if (j >= NUM_PROC) begin
            j = j - NUM_PROC;
         end
         cand = PTR_W'(j);
         if (req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   logic release_now;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_idx_d   = gnt_idx_q;
      cnt_d       = cnt_q;
      resp_d      = resp_q;
      src_d       = src_q;
      dest_d      = dest_q;
      tout_err_d  = tout_err_q;
      bad_err_d   = bad_err_q | (|req_bad);
      release_now = 1'b0;

      case (state_q)
         // The RELEASE cycle is the mandatory gap; arbitrating at its end keeps that
         // gap to exactly one cycle while the pointer has already moved past the last owner.
         IDLE, RELEASE: begin
            state_d = IDLE;
            resp_d  = '0;
            src_d   = '0;
            dest_d  = '0;
            cnt_d   = '0;
            if (pick_found) begin
               state_d   = HOLD;
               gnt_idx_d = pick_idx;
               resp_d    = NUM_PROC'(1) << pick_idx;
               src_d     = 5'(pick_idx);
               dest_d    = dest_arr[pick_idx];
            end
         end

         HOLD: begin
            cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
            // First HOLD cycle masks a last flag left over from the previous burst.
            if ((cnt_q != '0) && bus.tx_last[gnt_idx_q]) begin
               release_now = 1'b1;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               release_now = 1'b1;
               tout_err_d  = 1'b1;
            end
            if (release_now) begin
               state_d  = RELEASE;
               resp_d   = '0;
               src_d    = '0;
               dest_d   = '0;
               rr_ptr_d = (gnt_idx_q == PTR_W'(NUM_PROC - 1)) ? '0 : gnt_idx_q + PTR_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            resp_d  = '0;
            src_d   = '0;
            dest_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         gnt_idx_q  <= '0;
         cnt_q      <= '0;
         resp_q     <= '0;
         src_q      <= '0;
         dest_q     <= '0;
         tout_err_q <= 1'b0;
         bad_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_idx_q  <= gnt_idx_d;
         cnt_q      <= cnt_d;
         resp_q     <= resp_d;
         src_q      <= src_d;
         dest_q     <= dest_d;
         tout_err_q <= tout_err_d;
         bad_err_q  <= bad_err_d;
      end
   end

   assign bus.master_response = resp_q;
   assign bus.grant_valid     = |resp_q;
   assign bus.grant_src       = src_q;
   assign bus.grant_dest      = dest_q;
   assign bus.timeout_err     = tout_err_q;
   assign bus.bad_dest_err    = bad_err_q;
endmodule
